// File: rtl/hack_pkg.sv
// hack_pkg: shared Hack ALU control words and the multiplier state encoding.
package hack_pkg;

    // ALU control words in {zx,nx,zy,ny,f,no} order
    localparam logic [5:0] ALU_X_PLUS_Y = 6'b000010;
    localparam logic [5:0] ALU_PASS_X   = 6'b001100;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DBL,
        DONE
    } mul_state_t;

endpackage

// File: rtl/hack_alu.sv
// hack_alu: the Hack 16-bit ALU (zx/nx/zy/ny preconditioning, add or and, optional negate).
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] f_out;

    // operand preconditioning, function select and output negation
    always_comb begin
        x_z   = zx ? '0 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? '0 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[15];
    end

endmodule

// File: rtl/hack_mul_seq.sv
// hack_mul_seq: 16-bit shift-and-add multiplier sequencing one hack_alu,
// one ALU operation per clock, with valid/ready handshakes on both sides.
// Optional macro HACK_MUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module hack_mul_seq
    import hack_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng,
    output logic        busy
);

    mul_state_t  state, state_nxt;
    logic [15:0] acc, acc_nxt;
    logic [15:0] mcand, mcand_nxt;
    logic [15:0] mplier, mplier_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctl;
    logic [15:0] alu_out;
    logic        alu_zr_unused;
    logic        alu_ng_unused;

    hack_alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (alu_ctl[5]),
        .nx  (alu_ctl[4]),
        .zy  (alu_ctl[3]),
        .ny  (alu_ctl[2]),
        .f   (alu_ctl[1]),
        .no  (alu_ctl[0]),
        .out (alu_out),
        .zr  (alu_zr_unused),
        .ng  (alu_ng_unused)
    );

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // next-state, ALU steering and handshake outputs
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        alu_x      = acc;
        alu_y      = mcand;
        alu_ctl    = ALU_PASS_X;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_nxt  = a;
                    mplier_nxt = b;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    state_nxt  = ADD;
`ifdef HACK_MUL_EARLY_EXIT_EN
                    if (b == '0)
                        state_nxt = DONE;
`endif
                end
            end
            ADD: begin
                busy      = 1'b1;
                alu_ctl   = mplier[0] ? ALU_X_PLUS_Y : ALU_PASS_X;
                acc_nxt   = alu_out;
                state_nxt = DBL;
            end
            DBL: begin
                busy       = 1'b1;
                alu_x      = mcand;
                alu_y      = mcand;
                alu_ctl    = ALU_X_PLUS_Y;
                mcand_nxt  = alu_out;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + 4'd1;
`ifdef HACK_MUL_EARLY_EXIT_EN
                state_nxt  = (cnt == 4'd15 || mplier[15:1] == '0) ? DONE : ADD;
`else
                state_nxt  = (cnt == 4'd15) ? DONE : ADD;
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // result and flags come straight from the accumulator
    always_comb begin
        product = acc;
        zr      = (acc == '0);
        ng      = acc[15];
    end

endmodule

// File: doc/hack_mul_seq.md
# hack_mul_seq

Multi-cycle 16-bit multiplier that sequences the existing `hack_alu` as its only arithmetic resource. It computes the low 16 bits of `a*b` by shift-and-add: one ALU operation per clock, alternating accumulate and double steps. The result is identical for signed (two's complement) and unsigned operands. It sits beside the CPU datapath as a coprocessor with a valid/ready handshake on both sides.

## Interface
- No parameters; data width is fixed at 16 bits (Hack word).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands `a`/`b` are valid.
- `in_ready` out 1: block accepts operands; high only in IDLE.
- `a` in 16: multiplicand.
- `b` in 16: multiplier.
- `out_valid` out 1: `product` is valid; high only in DONE.
- `out_ready` in 1: consumer accepts `product`.
- `product` out 16: `(a*b) mod 2^16`.
- `zr` out 1: `product == 0`.
- `ng` out 1: `product[15]`.
- `busy` out 1: high in ADD or DBL.

## Operation
- Registers:
  - `acc` (16 bits): the accumulator, and the source of `product`.
  - `mcand` (16 bits): the shifted multiplicand.
  - `mplier` (16 bits): the remaining multiplier bits.
  - `cnt` (4 bits): completed bit steps.
  - `state`.
- States and transitions:
  - **IDLE.** On `in_valid && in_ready`: `mcand<=a`, `mplier<=b`, `acc<=0`, `cnt<=0`, go to ADD.
  - **ADD.** ALU `x=acc`, `y=mcand`.
    - Control is `ALU_X_PLUS_Y` (000010) if `mplier[0]`, else `ALU_PASS_X` (001100).
    - `acc<=alu_out`, go to DBL.
  - **DBL.** ALU `x=mcand`, `y=mcand`, control `ALU_X_PLUS_Y`.
    - `mcand<=alu_out`, `mplier<=mplier>>1`, `cnt<=cnt+1`.
    - Go to DONE if `cnt==15`, else ADD.
  - **DONE.** `out_valid=1`. On `out_ready`, go to IDLE.
- The ALU is driven combinationally from `state`. In IDLE and DONE the ALU control is `ALU_PASS_X` with `x=acc`. All ALU arithmetic wraps mod 2^16; there is no overflow flag.
- `product`, `zr` and `ng` are derived combinationally from `acc`. They are held stable while `out_valid` is high and `out_ready` is low.
- `a`/`b` are sampled only at the accepting edge. Changes at any other time are ignored.
- `in_valid` in any state other than IDLE is ignored; `in_ready` is low there.

## Timing
- Reset values: `state=IDLE`, `acc=mcand=mplier=0`, `cnt=0`.
  - Outputs: `in_ready=1`, `out_valid=0`, `busy=0`, `product=0`, `zr=1`, `ng=0`.
- Accept at edge E0. `out_valid` rises after edge E32: 16 ADD/DBL pairs, so latency is 32 cycles.
- The result stays held in DONE for as long as `out_ready` is low. It drops after the edge at which `out_ready` is sampled high.
- `in_ready` rises in the cycle after the DONE handshake. The minimum issue interval is 34 cycles.
- Reset asserted mid-operation aborts immediately (asynchronously) to the reset values. No partial result is presented.

## Configuration
- `HACK_MUL_EARLY_EXIT_EN`
- **Defined:**
  - At accept, `b==0` goes directly to DONE with `acc=0`, so `out_valid` rises after E1.
  - In DBL, go to DONE when `mplier[15:1]==0`.
  - Latency is `2*(msb_index(b)+1)` cycles. `busy` semantics are unchanged.
- **Undefined:** a fixed 32-cycle latency for all operands.

## Structure
- Package `hack_pkg`:
  - ALU control constants `ALU_X_PLUS_Y=6'b000010` and `ALU_PASS_X=6'b001100`, in `{zx,nx,zy,ny,f,no}` order.
  - State enum: IDLE, ADD, DBL, DONE.
- One sub-module: the existing `hack_alu`, instantiated once and unmodified. Its `zr`/`ng` outputs are unused here.

## Test plan
- `a=3`, `b=5` → `product=15`, `zr=0`, `ng=0`. `out_valid` after 32 cycles; after 6 with `HACK_MUL_EARLY_EXIT_EN`.
- `a=-2` (0xFFFE), `b=-3` (0xFFFD) → `product=6`, after 32 cycles in both builds. Then `a=3`, `b=-3` → `product=0xFFF7` (-9), `ng=1`.
- `a=300`, `b=300` → `product=24464` (90000 mod 65536). Checks wrap-around.
- `a=1234`, `b=0` → `product=0`, `zr=1`. Latency is 32 cycles; 1 with early exit.
- Hold `out_ready=0` for 10 cycles in DONE:
  - `product` is stable and `in_ready=0`.
  - A new `in_valid` pulse during this window is ignored.
  - Raising `out_ready` returns the block to IDLE on the next edge.
- Assert `rst_n=0` at cycle 10 of an operation:
  - Outputs go to reset values immediately.
  - After release, `a=7`, `b=6` → `product=42`.
